mem_port_arbiter: RTL and testbench

Sequencer and arbiter for the single-ported instruction/data RAM. It shares one RAM port between the fetch requester (`if_*`) and the memory-stage load/store requester (`dm_*`). It serialises accesses, waits out the fixed RAM read latency and returns registered read data with a one-cycle valid pulse. It sits between Fetch/Memory and the RAM macro, and replaces the direct RAM hookup in the memory stage.

---
 rtl/mem_port_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares one single-ported RAM between fetch and data requesters,
//            serialising accesses and returning registered read data.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int RAM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ram_load,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    localparam int CNT_W = $clog2(RAM_LATENCY + 1);
    localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic              lat_dm;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [CNT_W-1:0]  cnt;
    logic [SC_W-1:0]   sc;

    logic arb_fire;
    logic pick_dm;
    logic wait_last;

    // Fetch only overrides dm priority once dm has won STARVE_LIMIT times in a row.
    always_comb begin
        arb_fire  = (state == IDLE) && !ram_load && (if_req || dm_req);
        pick_dm   = dm_req && !(if_req && (sc == SC_W'(STARVE_LIMIT)));
        wait_last = (cnt == CNT_W'(1));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        ram_en     = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = '0;
        ram_wdata  = '0;
        if_gnt     = 1'b0;
        dm_gnt     = 1'b0;
        case (state)
            IDLE: begin
                if (arb_fire) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                busy       = 1'b1;
                ram_en     = 1'b1;
                ram_we     = lat_we;
                ram_addr   = lat_addr;
                ram_wdata  = lat_wdata;
                if_gnt     = !lat_dm;
                dm_gnt     = lat_dm;
                state_next = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (wait_last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lat_dm    <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            cnt       <= '0;
            sc        <= '0;
            if_rvalid <= 1'b0;
            dm_rvalid <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
        end else begin
            if_rvalid <= 1'b0;
            dm_rvalid <= 1'b0;

            if (arb_fire) begin
                lat_dm    <= pick_dm;
                lat_we    <= pick_dm && dm_we;
                lat_addr  <= pick_dm ? dm_addr : if_addr;
                lat_wdata <= pick_dm ? dm_wdata : '0;
                if (pick_dm && if_req) begin
                    sc <= sc + SC_W'(1);
                end else begin
                    sc <= '0;
                end
            end else if ((state == IDLE) && !ram_load) begin
                sc <= '0;
            end

            if (state == ISSUE) begin
                cnt <= CNT_W'(RAM_LATENCY);
            end else if (state == WAIT) begin
                cnt <= cnt - CNT_W'(1);
            end

            // Capture at the end of the last WAIT cycle; the valid pulse lands in the next IDLE.
            if ((state == WAIT) && wait_last) begin
                if (lat_dm) begin
                    dm_rvalid <= 1'b1;
                    dm_rdata  <= lat_we ? '0 : ram_rdata;
                end else begin
                    if_rvalid <= 1'b1;
                    if_rdata  <= ram_rdata;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Directed self-checking bench for mem_port_arbiter with a RAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int L = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        ram_load;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        dm_req, dm_we;
    logic [31:0] dm_addr, dm_wdata;
    logic        dm_gnt, dm_rvalid;
    logic [31:0] dm_rdata;
    logic        ram_en, ram_we;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .RAM_LATENCY(L), .STARVE_LIMIT(4)
    ) dut (
        .clock(clock), .reset(reset), .ram_load(ram_load),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy)
    );

    // RAM model: read data is driven only in the cycle exactly L after ram_en.
    logic [31:0] mem [logic [31:0]];
    bit          preloaded = 1'b0;
    logic [31:0] pipe_d [L];
    logic        pipe_v [L];

    initial begin
        for (int i = 0; i < L; i++) begin
            pipe_d[i] = '0;
            pipe_v[i] = 1'b0;
        end
    end

    always @(posedge clock) begin
        if (!preloaded) begin
            mem[32'h40] = 32'hDEADBEEF;
            preloaded = 1'b1;
        end
        pipe_v[0] <= ram_en && !ram_we;
        pipe_d[0] <= (ram_en && !ram_we && mem.exists(ram_addr)) ? mem[ram_addr] : 32'h0;
        for (int i = 1; i < L; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_d[i] <= pipe_d[i-1];
        end
        if (ram_en && ram_we) mem[ram_addr] = ram_wdata;
    end

    assign ram_rdata = pipe_v[L-1] ? pipe_d[L-1] : 32'hBADBAD00;

    // Runs one request from the current negedge; returns cycle numbers relative to the request cycle (0).
    task automatic run_txn(input bit is_dm, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, output int gnt_cyc, output int rv_cyc,
                           output logic [31:0] rdata, output logic gnt_we,
                           output logic [31:0] gnt_addr);
        gnt_cyc = -1; rv_cyc = -1; rdata = '0; gnt_we = 1'b0; gnt_addr = '0;
        if (is_dm) begin
            dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        for (int c = 1; c <= 20 && rv_cyc < 0; c++) begin
            @(negedge clock);
            if (gnt_cyc < 0 && (is_dm ? dm_gnt : if_gnt)) begin
                gnt_cyc = c; gnt_we = ram_we; gnt_addr = ram_addr;
                if (is_dm) dm_req = 1'b0; else if_req = 1'b0;
            end
            if (is_dm ? dm_rvalid : if_rvalid) begin
                rv_cyc = c;
                rdata  = is_dm ? dm_rdata : if_rdata;
            end
        end
        dm_req = 1'b0; if_req = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; ram_load = 1'b0; if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
        repeat (2) @(negedge clock);
        checks++;
        if ({if_gnt, dm_gnt, if_rvalid, dm_rvalid, ram_en, ram_we, busy} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 0000000",
                     {if_gnt, dm_gnt, if_rvalid, dm_rvalid, ram_en, ram_we, busy});
        end
        checks++;
        if ({if_rdata, dm_rdata, ram_addr, ram_wdata} !== 128'h0) begin
            errors++;
            $display("FAIL reset_data: got %h expected 0", {if_rdata, dm_rdata, ram_addr, ram_wdata});
        end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_single_fetch();
        int g, r; logic [31:0] d, a; logic w;
        run_txn(1'b0, 1'b0, 32'h40, 32'h0, g, r, d, w, a);
        checks++; if (g !== 1) begin errors++; $display("FAIL fetch_gnt_cycle: got %0d expected 1", g); end
        checks++; if (a !== 32'h40) begin errors++; $display("FAIL fetch_ram_addr: got %h expected 00000040", a); end
        checks++; if (w !== 1'b0) begin errors++; $display("FAIL fetch_ram_we: got %b expected 0", w); end
        checks++; if (r !== 4) begin errors++; $display("FAIL fetch_rvalid_cycle: got %0d expected 4", r); end
        checks++; if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL fetch_rdata: got %h expected deadbeef", d); end
        @(negedge clock);
        checks++;
        if ({if_rvalid, busy, if_rdata} !== {2'b00, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL fetch_hold: got rv=%b busy=%b data=%h expected 0 0 deadbeef", if_rvalid, busy, if_rdata);
        end
    endtask

    task automatic test_store_load();
        int g, r; logic [31:0] d, a; logic w;
        run_txn(1'b1, 1'b1, 32'h100, 32'h12345678, g, r, d, w, a);
        checks++; if (g !== 1) begin errors++; $display("FAIL store_gnt_cycle: got %0d expected 1", g); end
        checks++; if (w !== 1'b1) begin errors++; $display("FAIL store_ram_we: got %b expected 1", w); end
        checks++; if (a !== 32'h100) begin errors++; $display("FAIL store_ram_addr: got %h expected 00000100", a); end
        checks++; if (r !== 4) begin errors++; $display("FAIL store_rvalid_cycle: got %0d expected 4", r); end
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL store_rdata: got %h expected 0", d); end
        // Issued from the store's rvalid cycle: the back-to-back case.
        run_txn(1'b1, 1'b0, 32'h100, 32'h0, g, r, d, w, a);
        checks++; if (g !== 1) begin errors++; $display("FAIL load_gnt_cycle: got %0d expected 1", g); end
        checks++; if (w !== 1'b0) begin errors++; $display("FAIL load_ram_we: got %b expected 0", w); end
        checks++; if (r !== 4) begin errors++; $display("FAIL load_rvalid_cycle: got %0d expected 4", r); end
        checks++; if (d !== 32'h12345678) begin errors++; $display("FAIL load_rdata: got %h expected 12345678", d); end
    endtask

    task automatic test_simultaneous();
        logic [9:0] seq = '0;
        int n = 0, last = -1, bad_gap = 0, both = 0;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100; if_req = 1'b1; if_addr = 32'h40;
        for (int c = 0; c < 100 && n < 10; c++) begin
            @(negedge clock);
            if (dm_gnt && if_gnt) both++;
            if (dm_gnt || if_gnt) begin
                seq[n] = dm_gnt;
                if (last >= 0 && (c - last) != L + 2) bad_gap++;
                last = c;
                n++;
            end
        end
        dm_req = 1'b0; if_req = 1'b0;
        checks++; if (n !== 10) begin errors++; $display("FAIL sim_grant_count: got %0d expected 10", n); end
        checks++; if (seq !== 10'b0111101111) begin errors++; $display("FAIL sim_grant_order: got %b expected 0111101111", seq); end
        checks++; if (bad_gap !== 0) begin errors++; $display("FAIL sim_grant_spacing: got %0d bad gaps expected 0", bad_gap); end
        checks++; if (both !== 0) begin errors++; $display("FAIL sim_double_grant: got %0d expected 0", both); end
        repeat (6) @(negedge clock);
    endtask

    task automatic test_reset_mid();
        int g, r, rv_seen = 0; logic [31:0] d, a; logic w;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100;
        @(negedge clock);
        checks++; if (dm_gnt !== 1'b1) begin errors++; $display("FAIL rst_mid_gnt: got %b expected 1", dm_gnt); end
        dm_req = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        #1;
        checks++;
        if ({if_gnt, dm_gnt, if_rvalid, dm_rvalid, ram_en, ram_we, busy, if_rdata, dm_rdata, ram_addr} !== '0) begin
            errors++;
            $display("FAIL rst_mid_outputs: busy=%b ram_en=%b if_rdata=%h dm_rdata=%h expected all 0",
                     busy, ram_en, if_rdata, dm_rdata);
        end
        @(negedge clock);
        reset = 1'b0;
        repeat (4) begin
            @(negedge clock);
            if (dm_rvalid || if_rvalid) rv_seen++;
        end
        checks++; if (rv_seen !== 0) begin errors++; $display("FAIL rst_mid_no_rvalid: got %0d expected 0", rv_seen); end
        run_txn(1'b1, 1'b0, 32'h100, 32'h0, g, r, d, w, a);
        checks++;
        if ({g, r, d} !== {32'd1, 32'd4, 32'h12345678}) begin
            errors++;
            $display("FAIL rst_mid_fresh: got gnt=%0d rv=%0d data=%h expected 1 4 12345678", g, r, d);
        end
    endtask

    task automatic test_ram_load();
        int blocked = 0;
        ram_load = 1'b1; if_req = 1'b1; if_addr = 32'h40;
        repeat (10) begin
            @(negedge clock);
            if (if_gnt || busy) blocked++;
        end
        checks++; if (blocked !== 0) begin errors++; $display("FAIL load_block: got %0d active cycles expected 0", blocked); end
        ram_load = 1'b0;
        @(negedge clock);
        checks++; if (if_gnt !== 1'b1) begin errors++; $display("FAIL load_release_gnt: got %b expected 1", if_gnt); end
        if_req = 1'b0;
        @(negedge clock);
        ram_load = 1'b1;
        repeat (2) @(negedge clock);
        checks++;
        if ({if_rvalid, if_rdata} !== {1'b1, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL load_inflight_rvalid: got rv=%b data=%h expected 1 deadbeef", if_rvalid, if_rdata);
        end
        ram_load = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_withdraw();
        int act = 0, ign = 0;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100;
        #2 dm_req = 1'b0;
        repeat (3) begin
            @(negedge clock);
            if (dm_gnt || busy) act++;
        end
        checks++; if (act !== 0) begin errors++; $display("FAIL withdraw_no_grant: got %0d expected 0", act); end
        dm_req = 1'b1;
        @(negedge clock);
        checks++; if (dm_gnt !== 1'b1) begin errors++; $display("FAIL ignore_dm_gnt: got %b expected 1", dm_gnt); end
        dm_req = 1'b0; if_req = 1'b1; if_addr = 32'h40;
        for (int c = 2; c <= 7; c++) begin
            @(negedge clock);
            if (c == 3) if_req = 1'b0;
            if (if_gnt) ign++;
            if (c == 4) begin
                checks++;
                if ({dm_rvalid, dm_rdata} !== {1'b1, 32'h12345678}) begin
                    errors++;
                    $display("FAIL ignore_dm_rvalid: got rv=%b data=%h expected 1 12345678", dm_rvalid, dm_rdata);
                end
            end
        end
        checks++; if (ign !== 0) begin errors++; $display("FAIL ignore_if_req: got %0d grants expected 0", ign); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_fetch();
        test_store_load();
        test_simultaneous();
        test_reset_mid();
        test_ram_load();
        test_withdraw();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
